// File: rtl/fx2_slave_fifo_emu.sv
`default_nettype none
// ============================================================================
//  Module   : fx2_slave_fifo_emu
//  Purpose  : Emulates a Cypress FX2 slave-FIFO: EP2OUT (host -> FD) and
//             EP4IN/EP6IN (FD -> host) with packet-length queues.
//  Revision : 1.0 - initial release
// ============================================================================
module fx2_slave_fifo_emu #(
    parameter     PINPOL       = "NEGATIVE",
    parameter int DEPTH        = 1024,
    parameter int AFULL_MARGIN = 4
) (
    input  logic       CLK,
    input  logic       n_rst_i,
    output logic       FLAGA,
    output logic       FLAGB,
    output logic       FLAGC,
    output logic       FLAGD,
    input  logic       SLOE,
    input  logic       SLRD,
    input  logic       SLWR,
    input  logic       PKTEND,
    input  logic [1:0] FIFOADR,
    inout  wire  [7:0] FD,
    input  logic [7:0] host_dat_i,
    input  logic       host_wr_i,
    output logic       host_ep2_full_o,
    input  logic       host_sel_i,
    input  logic       host_rd_i,
    output logic [7:0] host_dat_o,
    output logic       host_avail_o,
    output logic [9:0] host_len_o,
    output logic       host_last_o,
    input  logic       host_reset_i,
    output logic [2:0] err_o
);
    localparam int              c_AW     = $clog2(DEPTH);
    localparam int              c_CW     = c_AW + 1;
    localparam logic            c_ACT    = (PINPOL == "POSITIVE");
    localparam logic [c_CW-1:0] c_DEPTH  = c_CW'(DEPTH);
    localparam logic [c_CW-1:0] c_MARGIN = c_CW'(AFULL_MARGIN);

    logic w_sloe, w_slrd, w_slwr, w_pktend, w_flush;
    logic r_flagd_q, r_flaga_q, w_flaga_d;
    logic [2:0] r_err_q, w_err_d;
    logic [1:0] w_ovf, w_af, w_avail, w_last;
    logic [9:0] w_len [2];
    logic [7:0] w_head [2];

    assign w_sloe   = (SLOE == c_ACT);
    assign w_slrd   = (SLRD == c_ACT);
    assign w_slwr   = (SLWR == c_ACT);
    assign w_pktend = (PKTEND == c_ACT);
    // Flushing starts on the same edge FLAGD rises so flags and FIFOs agree.
    assign w_flush  = host_reset_i | r_flagd_q;

    // ---------------------------------------------------------------- EP2OUT
    logic [7:0]      r_ep2_mem [DEPTH];
    logic [c_AW-1:0] r_ep2_wp_q, w_ep2_wp_d, r_ep2_rp_q, w_ep2_rp_d;
    logic [c_CW-1:0] r_ep2_cnt_q, w_ep2_cnt_d;
    logic            w_ep2_push, w_ep2_pop, w_ep2_unf;

    always_comb begin
        w_ep2_push  = host_wr_i && (r_ep2_cnt_q != c_DEPTH) && !w_flush;
        w_ep2_pop   = w_slrd && (FIFOADR == 2'b00) && (r_ep2_cnt_q != '0) && !w_flush;
        w_ep2_unf   = w_slrd && (FIFOADR == 2'b00) && (r_ep2_cnt_q == '0) && !w_flush;
        w_ep2_wp_d  = r_ep2_wp_q + c_AW'(w_ep2_push);
        w_ep2_rp_d  = r_ep2_rp_q + c_AW'(w_ep2_pop);
        w_ep2_cnt_d = r_ep2_cnt_q + c_CW'(w_ep2_push) - c_CW'(w_ep2_pop);
        if (w_flush) begin
            w_ep2_wp_d  = '0;
            w_ep2_rp_d  = '0;
            w_ep2_cnt_d = '0;
        end
        w_flaga_d = (w_ep2_cnt_d == '0);
    end

    always_ff @(posedge CLK) begin
        if (w_ep2_push) r_ep2_mem[r_ep2_wp_q] <= host_dat_i;
    end

    assign FD = (n_rst_i && w_sloe && (FIFOADR == 2'b00)) ? r_ep2_mem[r_ep2_rp_q] : 8'hzz;
    assign host_ep2_full_o = (r_ep2_cnt_q == c_DEPTH);

    // ------------------------------------------------------- EP4IN / EP6IN
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_in
            logic [7:0]      r_mem [DEPTH];
            logic [c_AW-1:0] r_wp_q, w_wp_d, r_rp_q, w_rp_d;
            logic [c_CW-1:0] r_cnt_q, w_cnt_d;
            logic [9:0]      r_ucnt_q, w_ucnt_d, r_off_q, w_off_d;
            logic [3:0][9:0] r_lq_q, w_lq_d;
            logic [1:0]      r_qwp_q, w_qwp_d, r_qrp_q, w_qrp_d;
            logic [2:0]      r_qcnt_q, w_qcnt_d;
            logic            r_af_q, w_af_d;
            logic            w_wr, w_pe, w_acc, w_want, w_commit, w_rd, w_pop, w_retire;
            logic            w_ovf_l;
            logic [9:0]      w_ucnt_inc, w_hlen;

            always_comb begin
                w_hlen     = r_lq_q[r_qrp_q];
                w_wr       = w_slwr && (FIFOADR == 2'(gi + 1)) && !w_flush;
                w_pe       = w_pktend && (FIFOADR == 2'(gi + 1)) && !w_flush;
                w_acc      = w_wr && (r_cnt_q != c_DEPTH) && (r_qcnt_q != 3'd4);
                w_ucnt_inc = r_ucnt_q + 10'(w_acc);
                // A same-cycle byte is counted before PKTEND commits it.
                w_want     = (w_ucnt_inc == 10'd512) || w_pe;
                w_commit   = w_want && (r_qcnt_q != 3'd4);
                w_ovf_l    = (w_wr && !w_acc) || (w_want && !w_commit);
                w_ucnt_d   = w_commit ? 10'd0 : w_ucnt_inc;

                w_rd       = host_rd_i && (host_sel_i == 1'(gi)) && (r_qcnt_q != '0) && !w_flush;
                w_pop      = w_rd && (w_hlen != '0);
                w_retire   = w_rd && ((w_hlen == '0) || (r_off_q + 10'd1 == w_hlen));
                w_off_d    = w_retire ? 10'd0 : r_off_q + 10'(w_pop);

                w_wp_d     = r_wp_q + c_AW'(w_acc);
                w_rp_d     = r_rp_q + c_AW'(w_pop);
                w_cnt_d    = r_cnt_q + c_CW'(w_acc) - c_CW'(w_pop);
                w_lq_d     = r_lq_q;
                if (w_commit) w_lq_d[r_qwp_q] = w_ucnt_inc;
                w_qwp_d    = r_qwp_q + 2'(w_commit);
                w_qrp_d    = r_qrp_q + 2'(w_retire);
                w_qcnt_d   = r_qcnt_q + 3'(w_commit) - 3'(w_retire);
                if (w_flush) begin
                    w_wp_d   = '0;
                    w_rp_d   = '0;
                    w_cnt_d  = '0;
                    w_ucnt_d = '0;
                    w_off_d  = '0;
                    w_qwp_d  = '0;
                    w_qrp_d  = '0;
                    w_qcnt_d = '0;
                end
                w_af_d = ((c_DEPTH - w_cnt_d) < c_MARGIN) || (w_qcnt_d == 3'd4);
            end

            always_ff @(posedge CLK) begin
                if (w_acc) r_mem[r_wp_q] <= FD;
            end

            always_ff @(posedge CLK or negedge n_rst_i) begin
                if (!n_rst_i) begin
                    r_wp_q   <= '0;
                    r_rp_q   <= '0;
                    r_cnt_q  <= '0;
                    r_ucnt_q <= '0;
                    r_off_q  <= '0;
                    r_lq_q   <= '0;
                    r_qwp_q  <= '0;
                    r_qrp_q  <= '0;
                    r_qcnt_q <= '0;
                    r_af_q   <= 1'b0;
                end else begin
                    r_wp_q   <= w_wp_d;
                    r_rp_q   <= w_rp_d;
                    r_cnt_q  <= w_cnt_d;
                    r_ucnt_q <= w_ucnt_d;
                    r_off_q  <= w_off_d;
                    r_lq_q   <= w_lq_d;
                    r_qwp_q  <= w_qwp_d;
                    r_qrp_q  <= w_qrp_d;
                    r_qcnt_q <= w_qcnt_d;
                    r_af_q   <= w_af_d;
                end
            end

            assign w_ovf[gi]   = w_ovf_l;
            assign w_af[gi]    = r_af_q;
            assign w_avail[gi] = (r_qcnt_q != '0);
            assign w_len[gi]   = w_hlen;
            assign w_last[gi]  = (r_qcnt_q != '0) && (w_hlen != '0) && (r_off_q + 10'd1 == w_hlen);
            assign w_head[gi]  = r_mem[r_rp_q];
        end
    endgenerate

    always_comb begin
        host_avail_o = w_avail[host_sel_i];
        host_len_o   = host_avail_o ? w_len[host_sel_i] : 10'd0;
        host_last_o  = w_last[host_sel_i];
        host_dat_o   = host_avail_o ? w_head[host_sel_i] : 8'd0;
    end

    // ------------------------------------------------- flags and errors
    always_comb begin
        w_err_d = r_err_q | {w_sloe && (FIFOADR != 2'b00), |w_ovf, w_ep2_unf};
    end

    always_ff @(posedge CLK or negedge n_rst_i) begin
        if (!n_rst_i) begin
            r_ep2_wp_q  <= '0;
            r_ep2_rp_q  <= '0;
            r_ep2_cnt_q <= '0;
            r_flaga_q   <= 1'b1;
            r_flagd_q   <= 1'b0;
            r_err_q     <= '0;
        end else begin
            r_ep2_wp_q  <= w_ep2_wp_d;
            r_ep2_rp_q  <= w_ep2_rp_d;
            r_ep2_cnt_q <= w_ep2_cnt_d;
            r_flaga_q   <= w_flaga_d;
            r_flagd_q   <= host_reset_i;
            r_err_q     <= w_err_d;
        end
    end

    assign FLAGA = r_flaga_q ? c_ACT : ~c_ACT;
    assign FLAGB = w_af[0] ? c_ACT : ~c_ACT;
    assign FLAGC = w_af[1] ? c_ACT : ~c_ACT;
    assign FLAGD = r_flagd_q;
    assign err_o = r_err_q;

endmodule
`default_nettype wire

// File: tb/tb_fx2_slave_fifo_emu.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fx2_slave_fifo_emu
//  Purpose  : Scoreboard bench for fx2_slave_fifo_emu (negative pin polarity).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fx2_slave_fifo_emu;
    localparam int DEPTH = 1024;
    localparam int AFM   = 4;

    typedef struct {
        logic [7:0] dat;
        logic       last;
        logic [9:0] len;
        bit         chk_dat;
    } hexp_t;

    logic       clk = 1'b0;
    logic       n_rst_i = 1'b0;
    logic       sloe_n = 1'b1, slrd_n = 1'b1, slwr_n = 1'b1, pktend_n = 1'b1;
    logic [1:0] fifoadr = 2'b00;
    logic [7:0] fd_drv = 8'h00;
    logic       fd_oe = 1'b0;
    wire  [7:0] fd_bus;
    logic [7:0] host_dat_i = 8'h00;
    logic       host_wr_i = 1'b0, host_sel_i = 1'b0, host_rd_i = 1'b0, host_reset_i = 1'b0;
    logic       flaga, flagb, flagc, flagd, host_ep2_full_o, host_avail_o, host_last_o;
    logic [7:0] host_dat_o;
    logic [9:0] host_len_o;
    logic [2:0] err_o;

    int n_checks = 0;
    int n_errors = 0;
    logic [7:0] ep2_exp[$];
    hexp_t      host_exp[$];
    logic [7:0] mon_b;
    hexp_t      mon_h;

    assign fd_bus = fd_oe ? fd_drv : 8'hzz;
    always #5 clk = ~clk;

    fx2_slave_fifo_emu #(.PINPOL("NEGATIVE"), .DEPTH(DEPTH), .AFULL_MARGIN(AFM)) dut (
        .CLK(clk), .n_rst_i(n_rst_i),
        .FLAGA(flaga), .FLAGB(flagb), .FLAGC(flagc), .FLAGD(flagd),
        .SLOE(sloe_n), .SLRD(slrd_n), .SLWR(slwr_n), .PKTEND(pktend_n),
        .FIFOADR(fifoadr), .FD(fd_bus),
        .host_dat_i(host_dat_i), .host_wr_i(host_wr_i), .host_ep2_full_o(host_ep2_full_o),
        .host_sel_i(host_sel_i), .host_rd_i(host_rd_i), .host_dat_o(host_dat_o),
        .host_avail_o(host_avail_o), .host_len_o(host_len_o), .host_last_o(host_last_o),
        .host_reset_i(host_reset_i), .err_o(err_o)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Monitor: consumes expectations whenever the DUT is presenting read data.
    always @(negedge clk) begin
        if (n_rst_i && !slrd_n && !sloe_n && fifoadr == 2'b00 && ep2_exp.size() > 0) begin
            mon_b = ep2_exp.pop_front();
            chk("fd_data", 32'(fd_bus), 32'(mon_b));
        end
        if (n_rst_i && host_rd_i && host_exp.size() > 0) begin
            mon_h = host_exp.pop_front();
            chk("host_len", 32'(host_len_o), 32'(mon_h.len));
            chk("host_last", 32'(host_last_o), 32'(mon_h.last));
            if (mon_h.chk_dat) chk("host_dat", 32'(host_dat_o), 32'(mon_h.dat));
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic ep_write(input logic [1:0] adr, input logic [7:0] d, input bit pe);
        fifoadr = adr; fd_drv = d; fd_oe = 1'b1; slwr_n = 1'b0; pktend_n = pe ? 1'b0 : 1'b1;
        tick();
        slwr_n = 1'b1; pktend_n = 1'b1; fd_oe = 1'b0;
    endtask

    task automatic pkt_end(input logic [1:0] adr);
        fifoadr = adr; pktend_n = 1'b0;
        tick();
        pktend_n = 1'b1;
    endtask

    task automatic host_read(input logic [7:0] d, input logic last, input logic [9:0] len, input bit cd);
        hexp_t e;
        e.dat = d; e.last = last; e.len = len; e.chk_dat = cd;
        host_exp.push_back(e);
        host_rd_i = 1'b1;
        tick();
        host_rd_i = 1'b0;
    endtask

    task automatic host_push(input logic [7:0] d);
        host_dat_i = d; host_wr_i = 1'b1;
        tick();
        host_wr_i = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (2) tick();
        chk("rst_flaga", 32'(flaga), 32'd0);
        chk("rst_flagb", 32'(flagb), 32'd1);
        chk("rst_flagc", 32'(flagc), 32'd1);
        chk("rst_flagd", 32'(flagd), 32'd0);
        chk("rst_err", 32'(err_o), 32'd0);
        chk("rst_avail", 32'(host_avail_o), 32'd0);
        chk("rst_len", 32'(host_len_o), 32'd0);
        chk("rst_ep2_full", 32'(host_ep2_full_o), 32'd0);

        // First push lands on the first edge after reset release
        n_rst_i = 1'b1; host_dat_i = 8'h11; host_wr_i = 1'b1;
        tick();
        host_wr_i = 1'b0;
        chk("flaga_after_first_push", 32'(flaga), 32'd1);
        host_push(8'h22);
        host_push(8'h33);

        // EP2 drain via SLRD
        sloe_n = 1'b0; fifoadr = 2'b00; slrd_n = 1'b0;
        ep2_exp.push_back(8'h11); tick();
        chk("flaga_mid_drain", 32'(flaga), 32'd1);
        ep2_exp.push_back(8'h22); tick();
        ep2_exp.push_back(8'h33); tick();
        chk("flaga_empty", 32'(flaga), 32'd0);
        chk("err_before_underrun", 32'(err_o), 32'd0);
        tick();
        chk("err_underrun", 32'(err_o), 32'd1);
        slrd_n = 1'b1; sloe_n = 1'b1;

        // EP4 short packet then zero-length packet
        host_sel_i = 1'b0;
        ep_write(2'b01, 8'hA1, 0);
        ep_write(2'b01, 8'hA2, 0);
        ep_write(2'b01, 8'hA3, 0);
        chk("ep4_not_committed", 32'(host_avail_o), 32'd0);
        pkt_end(2'b01);
        chk("ep4_avail", 32'(host_avail_o), 32'd1);
        chk("ep4_len3", 32'(host_len_o), 32'd3);
        pkt_end(2'b01);
        host_read(8'hA1, 1'b0, 10'd3, 1);
        host_read(8'hA2, 1'b0, 10'd3, 1);
        host_read(8'hA3, 1'b1, 10'd3, 1);
        chk("zlp_avail", 32'(host_avail_o), 32'd1);
        chk("zlp_len", 32'(host_len_o), 32'd0);
        host_read(8'h00, 1'b0, 10'd0, 0);
        chk("zlp_retired", 32'(host_avail_o), 32'd0);

        // EP6 full packet auto-commit
        host_sel_i = 1'b1;
        for (int i = 0; i < 512; i++) ep_write(2'b10, 8'(i), 0);
        chk("ep6_avail", 32'(host_avail_o), 32'd1);
        chk("ep6_len512", 32'(host_len_o), 32'd512);
        chk("ep6_flagc", 32'(flagc), 32'd1);
        for (int i = 0; i < 512; i++) host_read(8'(i), (i == 511), 10'd512, 1);
        chk("ep6_drained", 32'(host_avail_o), 32'd0);

        // Write and PKTEND in the same cycle
        ep_write(2'b10, 8'hC1, 0);
        ep_write(2'b10, 8'hC2, 0);
        ep_write(2'b10, 8'hC3, 1);
        chk("ep6_len_same_cycle", 32'(host_len_o), 32'd3);
        host_read(8'hC1, 1'b0, 10'd3, 1);
        host_read(8'hC2, 1'b0, 10'd3, 1);
        host_read(8'hC3, 1'b1, 10'd3, 1);
        chk("err_no_overflow", 32'(err_o), 32'd1);

        // Bus contention
        fifoadr = 2'b01; sloe_n = 1'b0;
        tick();
        sloe_n = 1'b1;
        chk("err_contention", 32'(err_o), 32'd5);

        // EP4 almost-full and overflow
        host_sel_i = 1'b0;
        for (int i = 0; i < DEPTH - AFM; i++) ep_write(2'b01, 8'(i) ^ 8'h5A, 0);
        chk("flagb_at_margin", 32'(flagb), 32'd1);
        ep_write(2'b01, 8'(DEPTH - AFM) ^ 8'h5A, 0);
        chk("flagb_asserted", 32'(flagb), 32'd0);
        for (int i = DEPTH - AFM + 1; i < DEPTH; i++) ep_write(2'b01, 8'(i) ^ 8'h5A, 0);
        chk("err_at_full", 32'(err_o), 32'd5);
        ep_write(2'b01, 8'hEE, 0);
        ep_write(2'b01, 8'hEE, 0);
        chk("err_overflow", 32'(err_o), 32'd7);
        chk("ep4_len_full", 32'(host_len_o), 32'd512);
        for (int i = 0; i < 512; i++) host_read(8'(i) ^ 8'h5A, (i == 511), 10'd512, 1);
        chk("ep4_second_len", 32'(host_len_o), 32'd512);
        chk("flagb_relieved", 32'(flagb), 32'd1);

        // Host reset mid-transfer
        fifoadr = 2'b10; fd_drv = 8'h77; fd_oe = 1'b1; slwr_n = 1'b0;
        host_dat_i = 8'h44; host_wr_i = 1'b1; host_reset_i = 1'b1;
        tick();
        host_reset_i = 1'b0;
        chk("hrst_flagd", 32'(flagd), 32'd1);
        chk("hrst_flaga", 32'(flaga), 32'd0);
        chk("hrst_flagb", 32'(flagb), 32'd1);
        chk("hrst_avail", 32'(host_avail_o), 32'd0);
        tick();
        chk("hrst_flagd_clear", 32'(flagd), 32'd0);
        chk("hrst_push_ignored", 32'(flaga), 32'd0);
        host_sel_i = 1'b1;
        chk("hrst_ep6_ignored", 32'(host_avail_o), 32'd0);
        slwr_n = 1'b1; fd_oe = 1'b0; host_wr_i = 1'b0;

        // EP2 full and dropped push
        for (int i = 0; i < DEPTH; i++) host_push(8'(i * 7));
        chk("ep2_full", 32'(host_ep2_full_o), 32'd1);
        host_push(8'hEE);
        sloe_n = 1'b0; fifoadr = 2'b00; slrd_n = 1'b0;
        ep2_exp.push_back(8'd0); tick();
        ep2_exp.push_back(8'd7); tick();
        slrd_n = 1'b1; sloe_n = 1'b1;
        chk("ep2_not_full", 32'(host_ep2_full_o), 32'd0);
        host_push(8'h01);
        host_push(8'h02);
        chk("ep2_full_again", 32'(host_ep2_full_o), 32'd1);

        // Asynchronous reset mid-transfer
        ep_write(2'b10, 8'hD1, 1);
        chk("pre_rst_avail", 32'(host_avail_o), 32'd1);
        fifoadr = 2'b10; fd_drv = 8'hD2; fd_oe = 1'b1; slwr_n = 1'b0; host_rd_i = 1'b0;
        tick();
        n_rst_i = 1'b0;
        #1;
        chk("arst_flaga", 32'(flaga), 32'd0);
        chk("arst_flagb", 32'(flagb), 32'd1);
        chk("arst_flagc", 32'(flagc), 32'd1);
        chk("arst_flagd", 32'(flagd), 32'd0);
        chk("arst_err", 32'(err_o), 32'd0);
        chk("arst_avail", 32'(host_avail_o), 32'd0);
        chk("arst_len", 32'(host_len_o), 32'd0);
        chk("arst_last", 32'(host_last_o), 32'd0);
        chk("arst_dat", 32'(host_dat_o), 32'd0);
        chk("arst_ep2_full", 32'(host_ep2_full_o), 32'd0);
        slwr_n = 1'b1; fd_oe = 1'b0;
        tick();
        n_rst_i = 1'b1;
        tick();

        chk("ep2_scoreboard_empty", 32'(ep2_exp.size()), 32'd0);
        chk("host_scoreboard_empty", 32'(host_exp.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire
